// File: rtl/manhattan_distance_if.sv
// Bundles the point/center/axis inputs and the distance results of one
// manhattan_distance unit. The compute element owning the unit is the master.
interface manhattan_distance_if #(
   parameter int dim        = 3,
   parameter int data_range = 255
);
   localparam int dim_size    = $clog2(data_range);
   localparam int center_size = dim * dim_size;
   localparam int dist_size   = $clog2(data_range * dim);
   localparam int axis_size   = $clog2(dim);

   logic [axis_size-1:0]   axis;
   logic [center_size-1:0] point;
   logic [center_size-1:0] center;
   logic [dist_size-1:0]   dst;
   logic [dim_size-1:0]    axis_dst;
   logic                   dst_done;

   modport master (
      output axis, point, center,
      input  dst, axis_dst, dst_done
   );

   modport slave (
      input  axis, point, center,
      output dst, axis_dst, dst_done
   );
endinterface

// File: rtl/manhattan_distance.sv
// Free-running sequential L1 distance unit. It captures a point/center pair,
// then walks one dimension per cycle, accumulating |p[i]-c[i]|. It also keeps
// the difference along a selected axis for split decisions in the k-d tree.
// A result is produced every dim+1 cycles, with a one-cycle dst_done pulse.
module manhattan_distance #(
   parameter int dim        = 3,
   parameter int data_range = 255
) (
   input logic                 clk,
   input logic                 rst,
   manhattan_distance_if.slave bus
);
   localparam int dim_size    = $clog2(data_range);
   localparam int center_size = dim * dim_size;
   localparam int dist_size   = $clog2(data_range * dim);
   localparam int axis_size   = $clog2(dim);

   localparam logic [axis_size-1:0] lastIdx = axis_size'(dim - 1);

   typedef enum logic {
      LOAD,
      ACC
   } state_t;

   state_t                 r_state;
   logic [axis_size-1:0]   r_idx;
   logic [axis_size-1:0]   r_axis;
   logic [center_size-1:0] r_point;
   logic [center_size-1:0] r_center;
   logic [dist_size-1:0]   r_acc;
   logic [dim_size-1:0]    r_axisDiff;
   logic [dist_size-1:0]   r_dst;
   logic [dim_size-1:0]    r_axisDst;
   logic                   r_dstDone;

   logic [dim_size-1:0]    w_pSel;
   logic [dim_size-1:0]    w_cSel;
   logic [dim_size-1:0]    w_diff;
   logic [dist_size-1:0]   w_sum;
   logic                   w_isAxis;

   // Select the current dimension of the captured point and center and form
   // |p-c| as larger-minus-smaller so the subtraction can never underflow.
   always_comb begin
      w_pSel = '0;
      w_cSel = '0;
      for (int i = 0; i < dim; i++) begin
         if (r_idx == axis_size'(i)) begin
            w_pSel = r_point[i*dim_size +: dim_size];
            w_cSel = r_center[i*dim_size +: dim_size];
         end
      end
      w_diff   = (w_pSel >= w_cSel) ? (w_pSel - w_cSel) : (w_cSel - w_pSel);
      w_sum    = r_acc + dist_size'(w_diff);
      w_isAxis = (r_idx == r_axis);
   end

   // LOAD/ACC sequencer: capture inputs, accumulate one dimension per cycle,
   // then publish the registered results together with a one-cycle done pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= LOAD;
         r_idx      <= '0;
         r_axis     <= '0;
         r_point    <= '0;
         r_center   <= '0;
         r_acc      <= '0;
         r_axisDiff <= '0;
         r_dst      <= '0;
         r_axisDst  <= '0;
         r_dstDone  <= 1'b0;
      end else begin
         case (r_state)
            LOAD: begin
               r_point    <= bus.point;
               r_center   <= bus.center;
               r_axis     <= bus.axis;
               r_acc      <= '0;
               r_idx      <= '0;
               r_axisDiff <= '0;
               r_dstDone  <= 1'b0;
               r_state    <= ACC;
            end
            ACC: begin
               r_acc <= w_sum;
               if (w_isAxis) begin
                  r_axisDiff <= w_diff;
               end
               if (r_idx == lastIdx) begin
                  r_dst     <= w_sum;
                  r_axisDst <= w_isAxis ? w_diff : r_axisDiff;
                  r_dstDone <= 1'b1;
                  r_idx     <= '0;
                  r_state   <= LOAD;
               end else begin
                  r_idx <= r_idx + axis_size'(1);
               end
            end
            default: begin
               r_state <= LOAD;
            end
         endcase
      end
   end

   assign bus.dst      = r_dst;
   assign bus.axis_dst = r_axisDst;
   assign bus.dst_done = r_dstDone;

endmodule

// File: tb/tb_manhattan_distance.sv
// Directed bench for manhattan_distance: a table of point/center/axis vectors
// with hand-computed distances, plus sequences for reset abort, input
// stability across a computation and steady-state periodicity.
module tb_manhattan_distance;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks = 0;
   int errors = 0;

   manhattan_distance_if #(.dim(3), .data_range(255)) bus ();

   manhattan_distance #(.dim(3), .data_range(255)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [23:0] point;
      logic [23:0] center;
      logic [1:0]  axis;
      int          expDst;
      int          expAxis;
   } vec_t;

   vec_t vecs[8];

   // Advance one rising edge and settle away from it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [23:0] p, input logic [23:0] c,
                                input logic [1:0] a);
      bus.point  = p;
      bus.center = c;
      bus.axis   = a;
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Hold reset over a few edges, then release it mid-cycle.
   task automatic resetDut();
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
   endtask

   task automatic checkResult(input string name, input int expDst, input int expAxis);
      checkOutput({name, " dst"}, int'(bus.dst), expDst);
      checkOutput({name, " axis_dst"}, int'(bus.axis_dst), expAxis);
      checkOutput({name, " dst_done"}, int'(bus.dst_done), 1);
   endtask

   initial begin
      vecs[0] = '{"basic_axis1", 24'h1E140A, 24'h280F0D, 2'd1, 18, 5};
      vecs[1] = '{"max_range",   24'hFFFFFF, 24'h000000, 2'd2, 765, 255};
      vecs[2] = '{"axis_oor",    24'h1E140A, 24'h280F0D, 2'd3, 18, 0};
      vecs[3] = '{"basic_axis0", 24'h1E140A, 24'h280F0D, 2'd0, 18, 3};
      vecs[4] = '{"equal",       24'h123456, 24'h123456, 2'd0, 0, 0};
      vecs[5] = '{"swapped",     24'h280F0D, 24'h1E140A, 2'd2, 18, 10};
      vecs[6] = '{"center_max",  24'h000000, 24'hFFFFFF, 2'd0, 765, 255};
      vecs[7] = '{"mixed",       24'h6405C8, 24'h64FA32, 2'd1, 395, 245};

      applyStimulus(24'h0, 24'h0, 2'd0);

      // Reset values with clocking running
      rst = 1'b0;
      repeat (4) tick();
      checkOutput("reset dst", int'(bus.dst), 0);
      checkOutput("reset axis_dst", int'(bus.axis_dst), 0);
      checkOutput("reset dst_done", int'(bus.dst_done), 0);

      // Table: result lands on the 4th edge after release, pulse drops on the 5th
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].point, vecs[v].center, vecs[v].axis);
         resetDut();
         repeat (3) tick();
         checkOutput({vecs[v].name, " early done"}, int'(bus.dst_done), 0);
         tick();
         checkResult(vecs[v].name, vecs[v].expDst, vecs[v].expAxis);
         tick();
         checkOutput({vecs[v].name, " done fall"}, int'(bus.dst_done), 0);
         checkOutput({vecs[v].name, " dst hold"}, int'(bus.dst), vecs[v].expDst);
      end

      // Reset asserted mid-ACC clears outputs immediately and aborts the pulse
      applyStimulus(24'h1E140A, 24'h280F0D, 2'd1);
      resetDut();
      repeat (4) tick();
      checkOutput("pre-abort dst", int'(bus.dst), 18);
      repeat (2) tick();
      rst = 1'b0;
      #1;
      checkOutput("abort dst", int'(bus.dst), 0);
      checkOutput("abort axis_dst", int'(bus.axis_dst), 0);
      checkOutput("abort dst_done", int'(bus.dst_done), 0);
      tick();
      rst = 1'b1;
      repeat (3) tick();
      checkOutput("restart early done", int'(bus.dst_done), 0);
      tick();
      checkResult("restart", 18, 5);

      // Input stability: point changes after LOAD, only the next result sees it
      applyStimulus(24'h1E140A, 24'h280F0D, 2'd1);
      resetDut();
      tick();
      bus.point = 24'h000000;
      repeat (3) tick();
      checkResult("stable old", 18, 5);
      repeat (4) tick();
      checkResult("stable new", 68, 15);

      // Periodicity: with constant inputs the pulse repeats every 4 cycles
      for (int k = 0; k < 3; k++) begin
         for (int e = 1; e <= 4; e++) begin
            tick();
            checkOutput($sformatf("period%0d edge%0d done", k, e),
                        int'(bus.dst_done), (e == 4) ? 1 : 0);
            checkOutput($sformatf("period%0d edge%0d dst", k, e), int'(bus.dst), 68);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
